// File: rtl/sc_bist_ctrl.sv
// Standard-cell BIST controller: Galois LFSR patterns out, MISR signature in, compared to EXPECT.
// Optional abort input enabled by defining SC_BIST_ABORT_EN.
module sc_bist_ctrl #(
  parameter int unsigned      WIDTH  = 8,
  parameter logic [WIDTH-1:0] TAPS   = 8'hB8,
  parameter logic [WIDTH-1:0] SEED   = 8'h01,
  parameter int unsigned      CYCLES = 255,
  parameter int unsigned      LAT    = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
`ifdef SC_BIST_ABORT_EN
  input  logic             ABORT,
`endif
  input  logic [WIDTH-1:0] RESP,
  input  logic [WIDTH-1:0] EXPECT,
  output logic [WIDTH-1:0] PAT,
  output logic [WIDTH-1:0] SIG,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS
);

  localparam int unsigned      CNT_W      = $clog2(CYCLES + LAT + 1);
  localparam logic [WIDTH-1:0] ZERO_W     = {WIDTH{1'b0}};
  localparam logic [CNT_W-1:0] ZERO_C     = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1'b1);
  localparam logic [WIDTH-1:0] SEED_EFF   = (SEED == ZERO_W) ? WIDTH'(1'b1) : SEED;
  localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(CYCLES - 1);
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(CYCLES + LAT - 1);
  localparam bit               HAS_FLUSH  = (LAT > 0);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t           state_r;
  logic [WIDTH-1:0] lfsr_r;
  logic [WIDTH-1:0] misr_r;
  logic [CNT_W-1:0] cnt_r;
  logic             busy_r;
  logic             done_r;
  logic             misr_en_s;
  logic             abort_s;

  function automatic logic [WIDTH-1:0] galois_step(input logic [WIDTH-1:0] v);
    return (v >> 1) ^ (v[0] ? TAPS : ZERO_W);
  endfunction

`ifdef SC_BIST_ABORT_EN
  assign abort_s = ABORT;
`else
  assign abort_s = 1'b0;
`endif

  // The first LAT responses belong to no pattern yet, so capture waits for the pipeline.
  generate
    if (LAT == 0) begin : g_no_lat
      assign misr_en_s = 1'b1;
    end else begin : g_lat
      assign misr_en_s = (cnt_r >= CNT_W'(LAT));
    end
  endgenerate

  // Controller FSM with pattern generator, signature register and status flags.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= S_IDLE;
      lfsr_r  <= SEED_EFF;
      misr_r  <= ZERO_W;
      cnt_r   <= ZERO_C;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE, S_DONE: begin
          if (START) begin
            state_r <= S_RUN;
            lfsr_r  <= SEED_EFF;
            misr_r  <= ZERO_W;
            cnt_r   <= ZERO_C;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
          end
        end
        S_RUN: begin
          if (abort_s) begin
            state_r <= S_IDLE;
            lfsr_r  <= SEED_EFF;
            misr_r  <= ZERO_W;
            cnt_r   <= ZERO_C;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
          end else begin
            lfsr_r <= galois_step(lfsr_r);
            cnt_r  <= cnt_r + ONE_C;
            if (misr_en_s) begin
              misr_r <= galois_step(misr_r) ^ RESP;
            end
            if (cnt_r == RUN_LAST) begin
              if (HAS_FLUSH) begin
                state_r <= S_FLUSH;
              end else begin
                state_r <= S_DONE;
                busy_r  <= 1'b0;
                done_r  <= 1'b1;
              end
            end
          end
        end
        S_FLUSH: begin
          // Pattern generator is frozen; only in-flight responses are captured.
          if (abort_s) begin
            state_r <= S_IDLE;
            lfsr_r  <= SEED_EFF;
            misr_r  <= ZERO_W;
            cnt_r   <= ZERO_C;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
          end else begin
            misr_r <= galois_step(misr_r) ^ RESP;
            cnt_r  <= cnt_r + ONE_C;
            if (cnt_r == FLUSH_LAST) begin
              state_r <= S_DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end
          end
        end
        default: begin
          state_r <= S_IDLE;
          lfsr_r  <= SEED_EFF;
          misr_r  <= ZERO_W;
          cnt_r   <= ZERO_C;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign PAT  = lfsr_r;
  assign SIG  = misr_r;
  assign BUSY = busy_r;
  assign DONE = done_r;
  assign PASS = done_r & (misr_r == EXPECT);

endmodule

// File: tb/tb_sc_bist_ctrl.sv
// Directed bench for sc_bist_ctrl: a LAT=0 instance and a LAT=3 instance fed by a 3-clock delay line.
module tb_sc_bist_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic       resp_mode;
  logic [7:0] expect_v;
  logic [7:0] resp0, resp3, pat0, pat3, sig0, sig3;
  logic       busy0, busy3, done0, done3, pass0, pass3;
  logic [7:0] d1, d2, d3;

  int checks = 0;
  int errors = 0;
  int l0, l3;
  logic [7:0] ref_sig;
  logic [7:0] pat_seq [0:5];

  always #5 clk = ~clk;

  sc_bist_ctrl #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h01), .CYCLES(255), .LAT(0)) dut0 (
    .CLK(clk), .RST(rst), .START(start),
`ifdef SC_BIST_ABORT_EN
    .ABORT(abort),
`endif
    .RESP(resp0), .EXPECT(expect_v), .PAT(pat0), .SIG(sig0),
    .BUSY(busy0), .DONE(done0), .PASS(pass0)
  );

  sc_bist_ctrl #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h01), .CYCLES(255), .LAT(3)) dut3 (
    .CLK(clk), .RST(rst), .START(start),
`ifdef SC_BIST_ABORT_EN
    .ABORT(abort),
`endif
    .RESP(resp3), .EXPECT(expect_v), .PAT(pat3), .SIG(sig3),
    .BUSY(busy3), .DONE(done3), .PASS(pass3)
  );

  // Models a cell bank with three clocks of pipeline latency for dut3.
  always @(posedge clk) begin
    d1 <= pat3;
    d2 <= d1;
    d3 <= d2;
  end

  assign resp0 = resp_mode ? pat0 : 8'h00;
  assign resp3 = resp_mode ? d3 : 8'h00;

  function automatic logic [7:0] gstep(input logic [7:0] v);
    return (v >> 1) ^ (v[0] ? 8'hB8 : 8'h00);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  // Counts edges until each instance shows DONE, bounded so a stuck DUT still ends the run.
  task automatic run_both(input int already, output int lat0, output int lat3);
    int n;
    n = already;
    lat0 = -1;
    lat3 = -1;
    while ((lat0 < 0 || lat3 < 0) && n < 400) begin
      tick;
      n++;
      if (lat0 < 0 && done0 === 1'b1) lat0 = n;
      if (lat3 < 0 && done3 === 1'b1) lat3 = n;
    end
  endtask

  initial begin
    pat_seq[0] = 8'h01; pat_seq[1] = 8'hB8; pat_seq[2] = 8'h5C;
    pat_seq[3] = 8'h2E; pat_seq[4] = 8'h17; pat_seq[5] = 8'hB3;
    ref_sig = 8'h00;
    begin
      logic [7:0] p;
      p = 8'h01;
      for (int k = 0; k < 255; k++) begin
        ref_sig = gstep(ref_sig) ^ p;
        p = gstep(p);
      end
    end

    rst = 1'b1; start = 1'b0; abort = 1'b0; resp_mode = 1'b0; expect_v = 8'h00;
    tick;
    tick;
    chk("rst_busy", busy0, 1'b0);
    chk("rst_done", done0, 1'b0);
    chk("rst_pass", pass0, 1'b0);
    chk("rst_sig", sig0, 8'h00);
    chk("rst_pat0", pat0, 8'h01);
    chk("rst_pat3", pat3, 8'h01);
    rst = 1'b0;
    tick;
    chk("idle_hold_pat", pat0, 8'h01);

    // Pattern sequence and constant-zero response.
    pulse_start;
    chk("seq_busy", busy0, 1'b1);
    chk("seq_pat0", pat0, pat_seq[0]);
    for (int i = 1; i < 6; i++) begin
      tick;
      chk($sformatf("seq_pat%0d", i), pat0, pat_seq[i]);
    end
    run_both(5, l0, l3);
    chk("const_lat0", l0, 255);
    chk("const_lat3", l3, 258);
    chk("const_sig0", sig0, 8'h00);
    chk("const_sig3", sig3, 8'h00);
    chk("const_pass", pass0, 1'b1);
    chk("const_busy", busy0, 1'b0);
    chk("period_pat", pat0, 8'h01);
    expect_v = 8'h01;
    #1;
    chk("const_pass_bad", pass0, 1'b0);
    chk("const_pass_bad3", pass3, 1'b0);

    // Loopback with START held through most of RUN.
    resp_mode = 1'b1;
    expect_v = ref_sig;
    start = 1'b1;
    tick;
    repeat (199) tick;
    chk("held_busy", busy0, 1'b1);
    chk("held_done", done0, 1'b0);
    start = 1'b0;
    run_both(199, l0, l3);
    chk("loop_lat0", l0, 255);
    chk("loop_lat3", l3, 258);
    chk("loop_sig0", sig0, ref_sig);
    chk("loop_sig3", sig3, ref_sig);
    chk("loop_pass0", pass0, 1'b1);
    chk("loop_pass3", pass3, 1'b1);

    // Restart from DONE.
    pulse_start;
    chk("rs_busy", busy0, 1'b1);
    chk("rs_done", done0, 1'b0);
    chk("rs_sig", sig0, 8'h00);
    chk("rs_pat", pat0, 8'h01);
    chk("rs_pass", pass0, 1'b0);

    // Reset while cnt=100.
    repeat (100) tick;
    chk("mid_busy_pre", busy0, 1'b1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("mid_busy", busy0, 1'b0);
    chk("mid_done", done0, 1'b0);
    chk("mid_sig", sig0, 8'h00);
    chk("mid_pat", pat0, 8'h01);
    chk("mid_busy3", busy3, 1'b0);
    pulse_start;
    run_both(0, l0, l3);
    chk("post_lat0", l0, 255);
    chk("post_lat3", l3, 258);
    chk("post_sig0", sig0, ref_sig);
    chk("post_sig3", sig3, ref_sig);

`ifdef SC_BIST_ABORT_EN
    pulse_start;
    repeat (50) tick;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("ab_busy", busy0, 1'b0);
    chk("ab_done", done0, 1'b0);
    chk("ab_pat", pat0, 8'h01);
    chk("ab_sig", sig0, 8'h00);
    repeat (3) tick;
    chk("ab_done_hold", done0, 1'b0);
    pulse_start;
    run_both(0, l0, l3);
    chk("ab_run_lat0", l0, 255);
    abort = 1'b1;
    tick;
    chk("ab_in_done", done0, 1'b1);
    chk("ab_in_done_sig", sig0, ref_sig);
    abort = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
